// File: rtl/bin2bcd_seq_if.sv
// ============================================================================
// Module      : bin2bcd_seq_if
// Description : Request/result bundle for the sequential binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      d;
  logic                  blank_en;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     digit_en;
  logic                  busy;
  logic                  done;
  logic                  ovf;

  modport master (
    output start, d, blank_en,
    input  bcd, digit_en, busy, done, ovf
  );

  modport slave (
    input  start, d, blank_en,
    output bcd, digit_en, busy, done, ovf
  );
endinterface

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module      : bin2bcd_seq
// Description : Iterative double-dabble converter, one bit per clock, with
//               leading-zero blanking and overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  wire logic         clk,
  input  wire logic         rst,
  bin2bcd_seq_if.slave      bus
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);
  localparam int c_acc_w = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic                 w_load;
  logic                 w_step;
  logic                 w_fin;

  logic [WIDTH-1:0]     r_sr;
  logic [c_acc_w-1:0]   r_acc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_blank;
  logic                 r_ovf_sticky;

  logic [c_acc_w-1:0]   w_adj;
  logic [c_acc_w-1:0]   w_acc_nx;
  logic [WIDTH-1:0]     w_sr_nx;
  logic [DIGITS-1:0]    w_nz;
  logic [DIGITS-1:0]    w_en_blank;
  logic [DIGITS-1:0]    w_en_final;

  // Per-digit add-3 correction and nonzero/blanking terms
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      assign w_adj[4*k +: 4] = (r_acc[4*k +: 4] >= 4'd5) ? (r_acc[4*k +: 4] + 4'd3)
                                                         : r_acc[4*k +: 4];
      assign w_nz[k] = |r_acc[4*k +: 4];
      if (k == 0) begin : g_units
        assign w_en_blank[k] = 1'b1;
      end else begin : g_upper
        assign w_en_blank[k] = |w_nz[DIGITS-1:k];
      end
    end
  endgenerate

  assign {w_acc_nx, w_sr_nx} = {w_adj, r_sr} << 1;
  // An overflowed result is shown with every digit lit
  assign w_en_final = (!r_blank || r_ovf_sticky) ? {DIGITS{1'b1}} : w_en_blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_fin      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load     = 1'b1;
          w_state_nx = SHIFT;
        end
      end
      SHIFT: begin
        w_step = 1'b1;
        if (r_cnt == c_cnt_w'(1)) begin
          w_state_nx = FINISH;
        end
      end
      FINISH: begin
        w_fin      = 1'b1;
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr         <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_blank      <= 1'b0;
      r_ovf_sticky <= 1'b0;
      bus.bcd      <= '0;
      bus.digit_en <= '0;
      bus.ovf      <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (w_load) begin
        r_sr         <= bus.d;
        r_acc        <= '0;
        r_cnt        <= c_cnt_w'(WIDTH);
        r_blank      <= bus.blank_en;
        r_ovf_sticky <= 1'b0;
      end
      if (w_step) begin
        r_sr  <= w_sr_nx;
        r_acc <= w_acc_nx;
        r_cnt <= r_cnt - c_cnt_w'(1);
        if (w_adj[c_acc_w-1]) begin
          r_ovf_sticky <= 1'b1;
        end
      end
      if (w_fin) begin
        bus.bcd      <= r_acc;
        bus.digit_en <= w_en_final;
        bus.ovf      <= r_ovf_sticky;
        bus.done     <= 1'b1;
      end
    end
  end

  assign bus.busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 8: binary input width, range 4..32.
REQ-002 Parameter DIGITS, default 3: BCD output digit count, range 1..10.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: conversion request, sampled only in IDLE.
REQ-006 Port d, input, WIDTH: unsigned binary value, captured on an accepted start.
REQ-007 Port blank_en, input, 1: leading-zero blanking enable, captured on an accepted start.
REQ-008 Port bcd, output, 4*DIGITS: result digits; digit k occupies bits [4k+3:4k]; k=0 is units.
REQ-009 Port digit_en, output, DIGITS: per-digit display enable; bit k belongs to digit k.
REQ-010 Port busy, output, 1: high while a conversion is in progress.
REQ-011 Port done, output, 1: one-cycle pulse when bcd, digit_en and ovf update.
REQ-012 Port ovf, output, 1: the value did not fit in DIGITS digits.

Function
REQ-013 FSM states: IDLE, SHIFT, FINISH.
REQ-014 IDLE with start=1: load d into the shift register, clear the BCD accumulator, latch blank_en, load the iteration counter with WIDTH, go to SHIFT.
REQ-015 SHIFT runs one double-dabble iteration per cycle. Step 1: add 3 to every accumulator digit that is >= 5. Step 2: shift {accumulator, shift register} left by 1.
REQ-016 In every SHIFT iteration, a 1 shifted out of the top accumulator digit sets a sticky internal overflow bit.
REQ-017 SHIFT decrements the counter each cycle. After the WIDTH-th iteration the FSM goes to FINISH.
REQ-018 FINISH: register bcd, digit_en and ovf; assert done for exactly 1 cycle; return to IDLE.
REQ-019 Latency: start sampled at edge N gives done=1 in the cycle after edge N+WIDTH+1. The next start is accepted at edge N+WIDTH+2 at the earliest.
REQ-020 busy is high in SHIFT and FINISH and low in IDLE. busy rises in the cycle after start is accepted.
REQ-021 start while busy=1 is ignored. It has no effect on the running conversion and is not queued.
REQ-022 bcd, digit_en and ovf hold their last values between FINISH cycles. d changing during SHIFT has no effect.
REQ-023 With latched blank_en=1: digit_en[k]=1 iff any digit j>=k is nonzero, or k=0. Zero-valued interior digits stay enabled (105 gives 111). Units are always enabled.
REQ-024 With latched blank_en=0: digit_en is all ones.
REQ-025 On ovf=1, bcd holds the value modulo 10^DIGITS and digit_en is all ones.
REQ-026 The accumulator is DIGITS*4 bits wide. No digit ever exceeds 9 in the bcd output.
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 rst=1 at an edge: state goes to IDLE; bcd=0, digit_en=0, busy=0, done=0, ovf=0; counter, shift register and accumulator are cleared.
REQ-029 rst overrides start in the same cycle.
REQ-030 rst during SHIFT or FINISH aborts the conversion without a done pulse. Outputs take their reset values.
REQ-031 The first start after rst deasserts is accepted normally.

Verification (WIDTH=8, DIGITS=3 unless noted)
REQ-032 d=255, blank_en=1, start pulse -> done 9 cycles later; bcd=0x255, digit_en=111, ovf=0, busy high for 9 cycles.
REQ-033 d=105 and then d=7, blank_en=1:
- 105 -> bcd=0x105, digit_en=111.
- 7 -> bcd=0x007, digit_en=001.
REQ-034 d=0, blank_en=1 -> bcd=0x000, digit_en=001. Repeat with blank_en=0 -> digit_en=111.
REQ-035 DIGITS=2, d=123 -> ovf=1, bcd=0x23, digit_en=11.
REQ-036 Back-to-back and mid-operation events:
- start held high continuously with d=42 -> one conversion per 10 cycles, each bcd=0x042; starts during busy are ignored.
- rst pulse on the 4th SHIFT cycle -> no done pulse; all outputs 0.
REQ-037 WIDTH=16, DIGITS=5, d=65535 -> bcd=0x65535 and done 17 cycles after start.
